// File: rtl/vlc_table_arbiter_pkg.sv
// vlc_table_arbiter_pkg
//   Shared constants and types for the VLC table arbiter:
//   requester count, requester indices, watchdog limit and FSM state type.
package vlc_table_arbiter_pkg;

  localparam int VLC_ARB_NUM_REQ  = 4;

  localparam int VLC_REQ_CBP      = 0;
  localparam int VLC_REQ_MBTYPE   = 1;
  localparam int VLC_REQ_MOTION   = 2;
  localparam int VLC_REQ_DCT      = 3;

  localparam int VLC_ARB_MAX_HOLD = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

endpackage

// File: rtl/vlc_table_arbiter_if.sv
// vlc_table_arbiter_if
//   Walker / ROM side signals of the VLC table arbiter.
//   slave  : arbiter view (walker requests and ROM data in; grant, ROM port, status out)
//   master : walker / ROM / environment view (the opposite directions)
//   Req_I, Req_En_I   per-walker request and table enable
//   Req_Addr_I        per-walker address, walker i at [i*ADDR_W +: ADDR_W]
//   Grant_O           one-hot registered grant
//   Table_En_O/Addr_O ROM enable and address
//   Table_Data_I/O    ROM data in, broadcast to walkers
//   Busy_O            a grant is active
//   Timeout_O         one-cycle watchdog revoke pulse
//   Timeout_Id_O      index of the last revoked walker
interface vlc_table_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        Req_I;
  logic [NUM_REQ-1:0]        Req_En_I;
  logic [NUM_REQ*ADDR_W-1:0] Req_Addr_I;
  logic [NUM_REQ-1:0]        Grant_O;
  logic                      Table_En_O;
  logic [ADDR_W-1:0]         Table_Addr_O;
  logic [DATA_W-1:0]         Table_Data_I;
  logic [DATA_W-1:0]         Table_Data_O;
  logic                      Busy_O;
  logic                      Timeout_O;
  logic [ID_W-1:0]           Timeout_Id_O;

  modport slave (
    input  Req_I, Req_En_I, Req_Addr_I, Table_Data_I,
    output Grant_O, Table_En_O, Table_Addr_O, Table_Data_O,
           Busy_O, Timeout_O, Timeout_Id_O
  );

  modport master (
    output Req_I, Req_En_I, Req_Addr_I, Table_Data_I,
    input  Grant_O, Table_En_O, Table_Addr_O, Table_Data_O,
           Busy_O, Timeout_O, Timeout_Id_O
  );

endinterface

// File: rtl/vlc_table_arbiter_pick.sv
// vlc_arb_pick
//   Combinational one-hot picker for the VLC table arbiter.
//   eligible : walkers that may be granted this edge
//   rr_ptr   : last granted walker (only present with VLC_ARB_RR_EN)
//   winner   : one-hot pick, all zero when nothing is eligible
//   Macro VLC_ARB_RR_EN selects round-robin starting after rr_ptr;
//   otherwise fixed priority with index 0 highest.
module vlc_arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
`ifdef VLC_ARB_RR_EN
  input  logic [ID_W-1:0]    rr_ptr,
`endif
  output logic [NUM_REQ-1:0] winner
);

`ifdef VLC_ARB_RR_EN
  logic        found;
  int unsigned idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    // Walk NUM_REQ slots starting just past the last owner; the last slot
    // visited is the last owner itself, so a lone requester can be re-granted.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_REQ;
      if (!found && eligible[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`else
  // Isolate the lowest set bit: lowest index wins.
  always_comb begin
    winner = eligible & (~eligible + NUM_REQ'(1));
  end
`endif

endmodule

// File: rtl/vlc_table_arbiter.sv
// vlc_table_arbiter
//   Shares the single VLC/coefficient table ROM between the macroblock-layer
//   VLC walkers (0 CBP, 1 MB type, 2 motion, 3 DCT). One walker owns the ROM
//   for its whole decode; the owner's enable/address drive the ROM and ROM data
//   is broadcast to every walker. A hold watchdog revokes a stalled owner and
//   blocks it until it drops its request.
//   clock, resetn : clock and asynchronous active-low reset
//   bus           : vlc_table_arbiter_if.slave (requests, ROM port, status)
//   Macro VLC_ARB_RR_EN: round-robin pick with a pointer on the last owner;
//   undefined gives fixed priority (index 0 highest) and no pointer.
module vlc_table_arbiter
  import vlc_table_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = VLC_ARB_NUM_REQ,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = VLC_ARB_MAX_HOLD,
  parameter int CNT_W    = 6
) (
  input  logic                 clock,
  input  logic                 resetn,
  vlc_table_arbiter_if.slave   bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e             state_q,   state_d;
  logic [NUM_REQ-1:0] grant_q,   grant_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [NUM_REQ-1:0] block_q,   block_d;
  logic               timeout_q, timeout_d;
  logic [ID_W-1:0]    tid_q,     tid_d;
`ifdef VLC_ARB_RR_EN
  logic [ID_W-1:0]    rr_ptr_q,  rr_ptr_d;
`endif

  logic [NUM_REQ-1:0] pick_elig;
  logic [NUM_REQ-1:0] winner;
  logic [ID_W-1:0]    owner_idx;
  logic [ID_W-1:0]    win_idx;
  logic               owner_req;

  function automatic logic [ID_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  // The owner is excluded so a same-edge handover only picks other walkers;
  // in IDLE grant_q is zero and this reduces to Req_I & ~block_mask.
  assign pick_elig = bus.Req_I & ~block_q & ~grant_q;

  vlc_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .eligible (pick_elig),
`ifdef VLC_ARB_RR_EN
    .rr_ptr   (rr_ptr_q),
`endif
    .winner   (winner)
  );

  assign owner_idx = oh2idx(grant_q);
  assign win_idx   = oh2idx(winner);
  assign owner_req = |(grant_q & bus.Req_I);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    // A blocked walker is released once its request is seen low.
    block_d   = block_q & bus.Req_I;
    timeout_d = 1'b0;
    tid_d     = tid_q;
`ifdef VLC_ARB_RR_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|winner) begin
          state_d  = OWNED;
          grant_d  = winner;
          cnt_d    = '0;
`ifdef VLC_ARB_RR_EN
          rr_ptr_d = win_idx;
`endif
        end
      end
      OWNED: begin
        // Owner drop is tested first so it beats a coincident watchdog expiry.
        if (!owner_req) begin
          cnt_d = '0;
          if (|winner) begin
            grant_d  = winner;
`ifdef VLC_ARB_RR_EN
            rr_ptr_d = win_idx;
`endif
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          grant_d   = '0;
          cnt_d     = '0;
          timeout_d = 1'b1;
          tid_d     = owner_idx;
          block_d   = block_d | grant_q;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      cnt_q     <= '0;
      block_q   <= '0;
      timeout_q <= 1'b0;
      tid_q     <= '0;
`ifdef VLC_ARB_RR_EN
      rr_ptr_q  <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      block_q   <= block_d;
      timeout_q <= timeout_d;
      tid_q     <= tid_d;
`ifdef VLC_ARB_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  logic [ADDR_W-1:0] addr_mux;

  always_comb begin
    addr_mux = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) addr_mux = bus.Req_Addr_I[i*ADDR_W +: ADDR_W];
    end
  end

  assign bus.Grant_O      = grant_q;
  assign bus.Busy_O       = |grant_q;
  assign bus.Timeout_O    = timeout_q;
  assign bus.Timeout_Id_O = tid_q;
  assign bus.Table_En_O   = |(grant_q & bus.Req_En_I);
  assign bus.Table_Addr_O = addr_mux;
  assign bus.Table_Data_O = bus.Table_Data_I;

endmodule
